// File: rtl/riscv_definitions.sv
// Shared RISC-V datapath types.
// Holds the register address and data bus types used across the pipeline, plus
// the load funct3 encodings and the writeback FSM states.
package riscv_definitions;

  typedef logic [4:0] regAddr_t;

  // One 32-bit bus, viewable as a word, as halfwords or as bytes (index 0 = LSBs).
  typedef union packed {
    logic [31:0]      word;
    logic [1:0][15:0] halves;
    logic [3:0][7:0]  bytes;
  } dataBus_u;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } loadType_e;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wbState_e;

endpackage

// File: rtl/load_extract.sv
// Load data extraction: selects the byte/halfword addressed by the load offset
// from an aligned memory word and sign- or zero-extends it to 32 bits.
// Purely combinational so it can be shared with a future store/AMO path.
// Ports:
//   data_i      aligned memory word
//   load_type_i load funct3 (undefined encodings behave as a word load)
//   offset_i    byte offset of the load address
//   result_o    extended 32-bit result
module load_extract
  import riscv_definitions::*;
(
  input  dataBus_u  data_i,
  input  loadType_e load_type_i,
  input  logic [1:0] offset_i,
  output dataBus_u  result_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Halfword loads are naturally aligned, so only offset bit 1 matters for them.
  assign sel_byte = data_i.bytes[offset_i];
  assign sel_half = data_i.halves[offset_i[1]];

  always_comb begin
    result_o = data_i;
    case (load_type_i)
      LD_B:    result_o.word = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   result_o.word = {24'h0, sel_byte};
      LD_H:    result_o.word = {{16{sel_half[15]}}, sel_half};
      LD_HU:   result_o.word = {16'h0, sel_half};
      default: result_o      = data_i;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage driving the register-file write port.
// Retires single-cycle execute results with one cycle of latency, and waits in
// LOAD_WAIT for multi-cycle load responses while stalling upstream. Reports
// hazards on decode source registers that match the outstanding load.
// Optional feature: define LOAD_TIMEOUT_EN to abort a load after TIMEOUT_CYCLES
// cycles without a response (no write, one-cycle load_err pulse).
// Ports:
//   clk, rst_n, clk_en             clock, async active-low reset, clock enable
//   exe_*                          instruction presented by execute
//   mem_rsp_valid, mem_rsp_data    load response from data memory
//   rs1_addr, rs2_addr             decode source addresses
//   rd0_addr, rd0_wr_en, rd0_data  registered register-file write port
//   wb_stall                       upstream must hold exe_* inputs
//   rs1_pending, rs2_pending       source matches the outstanding load rd
//   load_err                       load timeout pulse (0 without the macro)
module reg_writeback
  import riscv_definitions::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       exe_valid,
  input  logic       exe_wr_en,
  input  regAddr_t   exe_rd_addr,
  input  dataBus_u   exe_result,
  input  logic       exe_is_load,
  input  loadType_e  exe_load_type,
  input  logic [1:0] exe_addr_lo,
  input  logic       mem_rsp_valid,
  input  dataBus_u   mem_rsp_data,
  input  regAddr_t   rs1_addr,
  input  regAddr_t   rs2_addr,
  output regAddr_t   rd0_addr,
  output logic       rd0_wr_en,
  output dataBus_u   rd0_data,
  output logic       wb_stall,
  output logic       rs1_pending,
  output logic       rs2_pending,
  output logic       load_err
);

  wbState_e   state_q, state_d;
  regAddr_t   pend_rd_q, pend_rd_d;
  loadType_e  ld_type_q, ld_type_d;
  logic [1:0] ld_off_q, ld_off_d;
  regAddr_t   rd0_addr_q, rd0_addr_d;
  logic       rd0_wr_en_q, rd0_wr_en_d;
  dataBus_u   rd0_data_q, rd0_data_d;
  dataBus_u   load_data;

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load_err_q, load_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  load_extract u_load_extract (
    .data_i      (mem_rsp_data),
    .load_type_i (ld_type_q),
    .offset_i    (ld_off_q),
    .result_o    (load_data)
  );

  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    ld_type_d   = ld_type_q;
    ld_off_d    = ld_off_q;
    rd0_addr_d  = rd0_addr_q;
    rd0_data_d  = rd0_data_q;
    rd0_wr_en_d = 1'b0;
`ifdef LOAD_TIMEOUT_EN
    cnt_d       = cnt_q;
    load_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (exe_valid) begin
          if (!exe_is_load) begin
            rd0_addr_d  = exe_rd_addr;
            rd0_data_d  = exe_result;
            rd0_wr_en_d = exe_wr_en && (exe_rd_addr != '0);
          end else begin
            // A load that does not write rd still waits for its response.
            pend_rd_d = exe_wr_en ? exe_rd_addr : '0;
            ld_type_d = exe_load_type;
            ld_off_d  = exe_addr_lo;
            state_d   = LOAD_WAIT;
`ifdef LOAD_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end
        end
      end
      LOAD_WAIT: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (mem_rsp_valid) begin
          rd0_addr_d  = pend_rd_q;
          rd0_data_d  = load_data;
          rd0_wr_en_d = (pend_rd_q != '0);
          state_d     = IDLE;
`ifdef LOAD_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = IDLE;
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_rd_q   <= '0;
      ld_type_q   <= LD_B;
      ld_off_q    <= '0;
      rd0_addr_q  <= '0;
      rd0_wr_en_q <= 1'b0;
      rd0_data_q  <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      ld_type_q   <= ld_type_d;
      ld_off_q    <= ld_off_d;
      rd0_addr_q  <= rd0_addr_d;
      rd0_wr_en_q <= rd0_wr_en_d;
      rd0_data_q  <= rd0_data_d;
    end
  end

`ifdef LOAD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else if (clk_en) begin
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

  assign rd0_addr    = rd0_addr_q;
  assign rd0_wr_en   = rd0_wr_en_q;
  assign rd0_data    = rd0_data_q;
  assign wb_stall    = (state_q == LOAD_WAIT);
  assign rs1_pending = wb_stall && (rs1_addr == pend_rd_q) && (pend_rd_q != '0);
  assign rs2_pending = wb_stall && (rs2_addr == pend_rd_q) && (pend_rd_q != '0);

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage that drives the register-file write port (rd0_addr, rd0_wr_en, rd0_data).
- Accepts single-cycle results from execute and multi-cycle load responses from the data-memory port.
- Extracts and sign/zero-extends load data, then issues one registered write per retired instruction.
- Stalls upstream while a load is outstanding and reports pending-load hazards on rs1/rs2 to decode.

Parameters:
TIMEOUT_CYCLES, 16, number of LOAD_WAIT cycles before abort; used only when LOAD_TIMEOUT_EN is defined; must be >= 1.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
clk_en  input  1  clock enable; all state and outputs hold when low
exe_valid  input  1  execute presents an instruction this cycle
exe_wr_en  input  1  instruction writes rd
exe_rd_addr  input  regAddr_t(5)  destination register
exe_result  input  dataBus_u(32)  ALU/JAL result, non-load only
exe_is_load  input  1  instruction is a load
exe_load_type  input  loadType_e(3)  load funct3
exe_addr_lo  input  2  byte offset of load address
mem_rsp_valid  input  1  load data valid this cycle
mem_rsp_data  input  dataBus_u(32)  aligned memory word
rs1_addr, rs2_addr  input  regAddr_t(5)  decode source addresses
rd0_addr  output  regAddr_t(5)  register-file write address
rd0_wr_en  output  1  register-file write enable
rd0_data  output  dataBus_u(32)  register-file write data
wb_stall  output  1  upstream must hold exe_* inputs
rs1_pending, rs2_pending  output  1  source matches an outstanding load destination
load_err  output  1  one-cycle pulse on load timeout; tied to 0 without the macro

Behaviour:
Reset:
- Asynchronous on rst_n low.
- state=IDLE; rd0_addr=0, rd0_wr_en=0, rd0_data=0; pend_rd=0; load_err=0.

Clock enable:
- All registers update only on clk rising edge with clk_en=1.

FSM states: IDLE, LOAD_WAIT.

IDLE:
- exe_valid=1 and exe_is_load=0:
  - Next cycle rd0_addr=exe_rd_addr and rd0_data=exe_result.
  - rd0_wr_en=exe_wr_en && exe_rd_addr!=0.
  - Latency is 1 cycle.
- exe_valid=1 and exe_is_load=1:
  - Capture pend_rd (forced to 0 if exe_wr_en=0), load type and offset.
  - Go to LOAD_WAIT; rd0_wr_en=0 next cycle.
- exe_valid=0: rd0_wr_en=0 next cycle.
- mem_rsp_valid in IDLE is ignored.

LOAD_WAIT:
- wb_stall=1 (combinational: state==LOAD_WAIT); exe_* inputs are ignored.
- On mem_rsp_valid=1:
  - rd0_addr=pend_rd, rd0_data=extract(mem_rsp_data), rd0_wr_en=(pend_rd!=0) next cycle.
  - Return to IDLE. wb_stall deasserts the cycle after the response.

Extraction:
- LD_B/LD_BU select byte exe_addr_lo; LD_H/LD_HU select half exe_addr_lo[1] (exe_addr_lo[0] ignored).
- LD_W: whole word, offset ignored.
- Signed types sign-extend to 32 bits; unsigned types zero-extend.
- Undefined funct3 behaves as LD_W.

Write port and hazards:
- rd0_wr_en is a single-cycle pulse per retired instruction; it is never asserted for x0.
- rsN_pending = state==LOAD_WAIT && rsN_addr==pend_rd && pend_rd!=0 (combinational).

Optional Feature:
LOAD_TIMEOUT_EN
- Defined:
  - A counter runs in LOAD_WAIT.
  - After TIMEOUT_CYCLES cycles with no response, return to IDLE with no write and pulse load_err for one cycle.
  - A response arriving in the same cycle as expiry wins: normal write, no error.
  - Late responses arriving in IDLE are ignored.
- Undefined: no counter; LOAD_WAIT persists until mem_rsp_valid; load_err=0 constant.

Decomposition:
- riscv_definitions package gains:
  - loadType_e: LD_B=3'b000, LD_H=3'b001, LD_W=3'b010, LD_BU=3'b100, LD_HU=3'b101.
  - wbState_e: IDLE, LOAD_WAIT.
- Existing regAddr_t and dataBus_u are reused.
- One sub-module, load_extract: purely combinational {data, type, offset} -> 32-bit result, reusable by the future store/AMO path.

Test Plan:
- Reset mid-LOAD_WAIT -> all outputs 0, state IDLE, wb_stall=0 immediately; then add x5=0x0000_1234 -> rd0_addr=5, rd0_data=0x1234, rd0_wr_en=1 one cycle later.
- Back-to-back ALU writes x1, x2, x0 -> pulses for x1 and x2 on consecutive cycles; rd0_wr_en=0 for x0.
- LB x7, offset 2, response 0x12_80_34_56 after 3 cycles -> wb_stall=1 for 3 cycles, rs1_pending=1 with rs1_addr=7, then x7=0xFFFF_FF80.
- LHU, offset 2, word 0x8001_0000 -> 0x0000_8001; LH with the same stimulus -> 0xFFFF_8001.
- clk_en=0 for 4 cycles during LOAD_WAIT with mem_rsp_valid high -> state and outputs frozen; response consumed on the first clk_en=1 edge.
- With LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no response -> load_err pulse at cycle 4, no write, IDLE; response on expiry cycle -> write, load_err=0.
